// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: steps each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, gates datapath write enables per
// phase, bounds bus waits with timeouts, and keeps a sticky trap and a
// retired-instruction counter. ALU/mux selects still come from the ctlpath.
module multicycle_sequencer #(
   parameter int FETCH_TIMEOUT = 16,
   parameter int MEM_TIMEOUT   = 16,
   parameter int INSTRET_WIDTH = 32
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [6:0]               inst_opcode,
   input  logic                     inst_valid,
   input  logic                     bus_ready,
   output logic                     inst_read_enable,
   output logic                     ir_write_enable,
   output logic                     data_mem_read_enable,
   output logic                     data_mem_write_enable,
   output logic                     mdr_write_enable,
   output logic                     regfile_write_enable,
   output logic                     pc_write_enable,
   output logic                     retire,
   output logic [INSTRET_WIDTH-1:0] instret,
   output logic [2:0]               state,
   output logic                     trap,
   output logic [1:0]               trap_cause
);

   localparam logic [2:0] FETCH     = 3'd0;
   localparam logic [2:0] DECODE    = 3'd1;
   localparam logic [2:0] EXECUTE   = 3'd2;
   localparam logic [2:0] MEMORY    = 3'd3;
   localparam logic [2:0] WRITEBACK = 3'd4;
   localparam logic [2:0] TRAP      = 3'd5;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_FETCH   = 2'd1;
   localparam logic [1:0] CAUSE_MEMORY  = 2'd2;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd3;

   // Opcode classes that change the phase sequence after DECODE
   localparam logic [1:0] CLASS_ALU   = 2'd0;  // goes through WRITEBACK
   localparam logic [1:0] CLASS_LOAD  = 2'd1;
   localparam logic [1:0] CLASS_STORE = 2'd2;
   localparam logic [1:0] CLASS_SHORT = 2'd3;  // BRANCH / MISC_MEM retire in EXECUTE

   localparam int MAX_TIMEOUT = (FETCH_TIMEOUT > MEM_TIMEOUT) ? FETCH_TIMEOUT : MEM_TIMEOUT;
   localparam int WAIT_WIDTH  = (MAX_TIMEOUT > 0) ? $clog2(MAX_TIMEOUT + 1) : 1;
   localparam logic [WAIT_WIDTH-1:0] FETCH_LAST =
      WAIT_WIDTH'((FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0);
   localparam logic [WAIT_WIDTH-1:0] MEM_LAST =
      WAIT_WIDTH'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
   localparam bit FETCH_LIMITED = (FETCH_TIMEOUT != 0);
   localparam bit MEM_LIMITED   = (MEM_TIMEOUT != 0);
   localparam int NUM_LEGAL     = 10;

   logic [2:0]               state_reg, state_next;
   logic [WAIT_WIDTH-1:0]    wait_reg, wait_next;
   logic [INSTRET_WIDTH-1:0] instret_reg, instret_next;
   logic [1:0]               cause_reg, cause_next;
   logic [1:0]               class_reg, class_next;
   logic [1:0]               decoded_class;
   logic [NUM_LEGAL-1:0]     opcode_hit;
   logic                     opcode_legal;

   logic inst_read_raw, ir_write_raw, dmem_read_raw, dmem_write_raw;
   logic mdr_write_raw, regfile_write_raw, pc_write_raw, retire_raw;

   // Table of the RV32I major opcodes this core implements
   function automatic logic [6:0] legal_opcode(input int idx);
      case (idx)
         0:       return 7'b0000011;  // LOAD
         1:       return 7'b0100011;  // STORE
         2:       return 7'b0010011;  // OP_IMM
         3:       return 7'b0110011;  // OP
         4:       return 7'b0110111;  // LUI
         5:       return 7'b0010111;  // AUIPC
         6:       return 7'b1101111;  // JAL
         7:       return 7'b1100111;  // JALR
         8:       return 7'b1100011;  // BRANCH
         default: return 7'b0001111;  // MISC_MEM
      endcase
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LEGAL; gi++) begin : g_legal
         assign opcode_hit[gi] = (inst_opcode == legal_opcode(gi));
      end
   endgenerate

   assign opcode_legal = |opcode_hit;

   // Classify the opcode presented during DECODE
   always_comb begin
      decoded_class = CLASS_ALU;
      case (inst_opcode)
         7'b0000011:             decoded_class = CLASS_LOAD;
         7'b0100011:             decoded_class = CLASS_STORE;
         7'b1100011, 7'b0001111: decoded_class = CLASS_SHORT;
         default:                decoded_class = CLASS_ALU;
      endcase
   end

   // Phase sequencing, per-phase enables and trap cause selection
   always_comb begin
      state_next        = state_reg;
      cause_next        = cause_reg;
      class_next        = class_reg;
      inst_read_raw     = 1'b0;
      ir_write_raw      = 1'b0;
      dmem_read_raw     = 1'b0;
      dmem_write_raw    = 1'b0;
      mdr_write_raw     = 1'b0;
      regfile_write_raw = 1'b0;
      pc_write_raw      = 1'b0;
      retire_raw        = 1'b0;
      case (state_reg)
         FETCH: begin
            inst_read_raw = 1'b1;
            if (inst_valid) begin
               ir_write_raw = 1'b1;
               state_next   = DECODE;
            end else if (FETCH_LIMITED && (wait_reg == FETCH_LAST)) begin
               state_next = TRAP;
               cause_next = CAUSE_FETCH;
            end
         end
         DECODE: begin
            class_next = decoded_class;
            if (opcode_legal) begin
               state_next = EXECUTE;
            end else begin
               state_next = TRAP;
               cause_next = CAUSE_ILLEGAL;
            end
         end
         EXECUTE: begin
            case (class_reg)
               CLASS_LOAD, CLASS_STORE: state_next = MEMORY;
               CLASS_SHORT: begin
                  pc_write_raw = 1'b1;
                  retire_raw   = 1'b1;
                  state_next   = FETCH;
               end
               default: state_next = WRITEBACK;
            endcase
         end
         MEMORY: begin
            dmem_read_raw  = (class_reg == CLASS_LOAD);
            dmem_write_raw = (class_reg != CLASS_LOAD);
            if (bus_ready) begin
               if (class_reg == CLASS_LOAD) begin
                  mdr_write_raw = 1'b1;
                  state_next    = WRITEBACK;
               end else begin
                  pc_write_raw = 1'b1;
                  retire_raw   = 1'b1;
                  state_next   = FETCH;
               end
            end else if (MEM_LIMITED && (wait_reg == MEM_LAST)) begin
               state_next = TRAP;
               cause_next = CAUSE_MEMORY;
            end
         end
         WRITEBACK: begin
            regfile_write_raw = 1'b1;
            pc_write_raw      = 1'b1;
            retire_raw        = 1'b1;
            state_next        = FETCH;
         end
         TRAP: begin
            state_next = TRAP;
         end
         default: begin
            state_next = FETCH;
         end
      endcase
   end

   // Wait counter restarts on every phase change and only runs while a bus is pending
   always_comb begin
      wait_next = '0;
      if ((state_next == state_reg) && ((state_reg == FETCH) || (state_reg == MEMORY))) begin
         wait_next = wait_reg + WAIT_WIDTH'(1);
      end
   end

   // Retired-instruction count, wrapping at its natural width
   always_comb begin
      instret_next = instret_reg;
      if (retire_raw) begin
         instret_next = instret_reg + INSTRET_WIDTH'(1);
      end
   end

   // Sequencer state registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg   <= FETCH;
         wait_reg    <= '0;
         instret_reg <= '0;
         cause_reg   <= CAUSE_NONE;
         class_reg   <= CLASS_ALU;
      end else begin
         state_reg   <= state_next;
         wait_reg    <= wait_next;
         instret_reg <= instret_next;
         cause_reg   <= cause_next;
         class_reg   <= class_next;
      end
   end

   // Enables are held off while reset is low so an abandoned instruction leaves no trace
   assign inst_read_enable      = inst_read_raw     & reset;
   assign ir_write_enable       = ir_write_raw      & reset;
   assign data_mem_read_enable  = dmem_read_raw     & reset;
   assign data_mem_write_enable = dmem_write_raw    & reset;
   assign mdr_write_enable      = mdr_write_raw     & reset;
   assign regfile_write_enable  = regfile_write_raw & reset;
   assign pc_write_enable       = pc_write_raw      & reset;
   assign retire                = retire_raw        & reset;

   assign instret    = instret_reg;
   assign state      = state_reg;
   assign trap       = (state_reg == TRAP);
   assign trap_cause = cause_reg;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: the driver pushes the expected
// outcome of each instruction, the monitor measures each instruction as it
// runs and compares at the retire pulse or on trap entry.
module tb_multicycle_sequencer;

   localparam int IW = 3;

   logic          clock;
   logic          reset;
   logic [6:0]    inst_opcode;
   logic          inst_valid;
   logic          bus_ready;
   logic          inst_read_enable;
   logic          ir_write_enable;
   logic          data_mem_read_enable;
   logic          data_mem_write_enable;
   logic          mdr_write_enable;
   logic          regfile_write_enable;
   logic          pc_write_enable;
   logic          retire;
   logic [IW-1:0] instret;
   logic [2:0]    state;
   logic          trap;
   logic [1:0]    trap_cause;

   typedef struct {
      int kind;     // 0 retire, 1 trap
      int lat;      // cycles from first FETCH to retire (inclusive) or to trap entry (exclusive)
      int ir;
      int rd;
      int wr;
      int mdr;
      int rf;
      int pc;
      int instret;  // count after retire
      int cause;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   multicycle_sequencer #(
      .FETCH_TIMEOUT(4),
      .MEM_TIMEOUT  (6),
      .INSTRET_WIDTH(IW)
   ) dut (
      .clock                (clock),
      .reset                (reset),
      .inst_opcode          (inst_opcode),
      .inst_valid           (inst_valid),
      .bus_ready            (bus_ready),
      .inst_read_enable     (inst_read_enable),
      .ir_write_enable      (ir_write_enable),
      .data_mem_read_enable (data_mem_read_enable),
      .data_mem_write_enable(data_mem_write_enable),
      .mdr_write_enable     (mdr_write_enable),
      .regfile_write_enable (regfile_write_enable),
      .pc_write_enable      (pc_write_enable),
      .retire               (retire),
      .instret              (instret),
      .state                (state),
      .trap                 (trap),
      .trap_cause           (trap_cause)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic exp_t mk(input int kind, input int lat, input int ir, input int rd,
                               input int wr, input int mdr, input int rf, input int pc,
                               input int ir_count, input int cause);
      exp_t e;
      e.kind = kind; e.lat = lat; e.ir = ir; e.rd = rd; e.wr = wr;
      e.mdr = mdr; e.rf = rf; e.pc = pc; e.instret = ir_count; e.cause = cause;
      return e;
   endfunction

   function automatic logic any_enable();
      return inst_read_enable | ir_write_enable | data_mem_read_enable |
             data_mem_write_enable | mdr_write_enable | regfile_write_enable |
             pc_write_enable | retire;
   endfunction

   // Drive one instruction, reacting to the DUT phase; returns just after the
   // edge that brings it back to FETCH or into TRAP.
   task automatic run_instr(input logic [6:0] op, input int fwait, input int mwait, input exp_t e);
      int fc, mc, guard;
      bit left, done;
      fc = 0; mc = 0; guard = 0; left = 0; done = 0;
      sb.push_back(e);
      while (!done) begin
         inst_valid  = 1'b0;
         bus_ready   = 1'b0;
         inst_opcode = 7'b1110011;  // junk outside FETCH/DECODE must not matter
         case (state)
            3'd0: begin
               inst_opcode = op;
               if (fc == fwait) inst_valid = 1'b1;
               else fc++;
            end
            3'd1: inst_opcode = op;
            3'd3: begin
               if (mc == mwait) bus_ready = 1'b1;
               else mc++;
            end
            default: ;
         endcase
         @(posedge clock); #1;
         guard++;
         if (state != 3'd0) left = 1'b1;
         if ((state == 3'd5) || (left && (state == 3'd0))) done = 1'b1;
         else if (guard >= 200) begin
            chk("run_timeout", 1, 0);
            done = 1'b1;
         end
      end
      inst_valid = 1'b0;
      bus_ready  = 1'b0;
   endtask

   // Hold reset with active-looking inputs, then check the reset state
   task automatic do_reset();
      @(posedge clock); #1;
      reset       = 1'b0;
      inst_valid  = 1'b1;
      bus_ready   = 1'b1;
      inst_opcode = 7'b0010011;
      #1;
      chk("reset_enables_forced", any_enable(), 0);
      repeat (2) @(posedge clock);
      #1;
      chk("reset_state", state, 0);
      chk("reset_instret", instret, 0);
      chk("reset_trap", trap, 0);
      chk("reset_cause", trap_cause, 0);
      chk("reset_enables_held", any_enable(), 0);
      inst_valid = 1'b0;
      bus_ready  = 1'b0;
      reset      = 1'b1;
      $display("reset released at %0t", $time);
   endtask

   // Monitor: measures each instruction and checks it against the scoreboard
   initial begin
      int lat, ir_c, rd_c, wr_c, mdr_c, rf_c, pc_c, pend_val;
      bit active, pend, prev_trap;
      exp_t e;
      lat = 0; ir_c = 0; rd_c = 0; wr_c = 0; mdr_c = 0; rf_c = 0; pc_c = 0;
      pend_val = 0; active = 0; pend = 0; prev_trap = 0;
      forever begin
         @(negedge clock);
         if (!reset) begin
            active = 0; pend = 0; prev_trap = 0;
            continue;
         end
         if (pend) begin
            chk("instret_after_retire", instret, pend_val);
            pend = 0;
         end
         if (trap) begin
            if (!prev_trap) begin
               if (sb.size() == 0) begin
                  chk("unexpected_trap", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("event_kind", 1, e.kind);
                  chk("trap_cause", trap_cause, e.cause);
                  chk("trap_latency", lat, e.lat);
                  chk("trap_ir_writes", ir_c, e.ir);
                  chk("trap_mem_reads", rd_c, e.rd);
                  chk("trap_mem_writes", wr_c, e.wr);
                  chk("trap_pc_writes", pc_c, e.pc);
                  chk("trap_rf_writes", rf_c, e.rf);
                  $display("trap cause=%0d after %0d cycles", trap_cause, lat);
               end
            end
            prev_trap = 1;
            active    = 0;
            continue;
         end
         prev_trap = 0;
         if (!active && (state == 3'd0)) begin
            active = 1;
            lat = 0; ir_c = 0; rd_c = 0; wr_c = 0; mdr_c = 0; rf_c = 0; pc_c = 0;
         end
         if (active) begin
            lat++;
            ir_c  += int'(ir_write_enable);
            rd_c  += int'(data_mem_read_enable);
            wr_c  += int'(data_mem_write_enable);
            mdr_c += int'(mdr_write_enable);
            rf_c  += int'(regfile_write_enable);
            pc_c  += int'(pc_write_enable);
         end
         if (retire) begin
            if (sb.size() == 0) begin
               chk("unexpected_retire", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("event_kind", 0, e.kind);
               chk("retire_latency", lat, e.lat);
               chk("ir_writes", ir_c, e.ir);
               chk("mem_reads", rd_c, e.rd);
               chk("mem_writes", wr_c, e.wr);
               chk("mdr_writes", mdr_c, e.mdr);
               chk("rf_writes", rf_c, e.rf);
               chk("pc_writes", pc_c, e.pc);
               pend     = 1;
               pend_val = e.instret;
               $display("retire after %0d cycles rf=%0d mdr=%0d expect instret=%0d",
                        lat, rf_c, mdr_c, e.instret);
            end
            active = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit any_en;
      reset       = 1'b0;
      inst_valid  = 1'b0;
      bus_ready   = 1'b0;
      inst_opcode = 7'b0;
      do_reset();

      //        opcode      fwait mwait  kind lat ir rd wr mdr rf pc instret cause
      run_instr(7'b0010011, 0, 0,  mk(0, 4, 1, 0, 0, 0, 1, 1, 1, 0));  // ADDI
      run_instr(7'b0000011, 0, 3,  mk(0, 8, 1, 4, 0, 1, 1, 1, 2, 0));  // LW, 3 waits
      run_instr(7'b1100011, 0, 0,  mk(0, 3, 1, 0, 0, 0, 0, 1, 3, 0));  // BEQ
      run_instr(7'b0100011, 0, 0,  mk(0, 4, 1, 0, 1, 0, 0, 1, 4, 0));  // SW
      run_instr(7'b0100011, 0, 5,  mk(0, 9, 1, 0, 6, 0, 0, 1, 5, 0));  // SW, ready on last cycle

      // Reset pulse in MEMORY of a store
      inst_opcode = 7'b0100011;
      inst_valid  = 1'b1;
      @(posedge clock); #1;
      inst_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("mid_store_state", state, 3);
      chk("mid_store_write", data_mem_write_enable, 1);
      #2 reset = 1'b0;
      #1;
      chk("abort_write_dropped", data_mem_write_enable, 0);
      chk("abort_enables", any_enable(), 0);
      chk("abort_instret", instret, 0);
      chk("abort_state", state, 0);
      @(posedge clock); #1;
      reset = 1'b1;
      chk("release_state", state, 0);
      $display("store abandoned by reset");

      run_instr(7'b0010011, 3, 0,  mk(0, 7, 1, 0, 0, 0, 1, 1, 1, 0));  // ADDI, valid on 4th fetch cycle
      run_instr(7'b1101111, 1, 0,  mk(0, 5, 1, 0, 0, 0, 1, 1, 2, 0));  // JAL
      run_instr(7'b0110111, 0, 0,  mk(0, 4, 1, 0, 0, 0, 1, 1, 3, 0));  // LUI
      run_instr(7'b0010111, 0, 0,  mk(0, 4, 1, 0, 0, 0, 1, 1, 4, 0));  // AUIPC
      run_instr(7'b1100111, 0, 0,  mk(0, 4, 1, 0, 0, 0, 1, 1, 5, 0));  // JALR
      run_instr(7'b0110011, 0, 0,  mk(0, 4, 1, 0, 0, 0, 1, 1, 6, 0));  // OP
      run_instr(7'b1100011, 0, 0,  mk(0, 3, 1, 0, 0, 0, 0, 1, 7, 0));  // BEQ
      run_instr(7'b0001111, 0, 0,  mk(0, 3, 1, 0, 0, 0, 0, 1, 0, 0));  // FENCE, instret wraps
      run_instr(7'b0000011, 0, 99, mk(1, 9, 1, 6, 0, 0, 0, 0, 0, 2));  // LW, memory timeout

      do_reset();
      run_instr(7'b1110011, 0, 0,  mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 3));  // ECALL illegal
      any_en = 1'b0;
      for (int i = 0; i < 20; i++) begin
         inst_valid  = 1'b1;
         bus_ready   = 1'b1;
         inst_opcode = (i % 2 == 0) ? 7'b0010011 : 7'b0000011;
         @(posedge clock); #1;
         any_en = any_en | any_enable();
      end
      inst_valid = 1'b0;
      bus_ready  = 1'b0;
      chk("trap_hold_enables", any_en, 0);
      chk("trap_hold_state", state, 5);
      chk("trap_hold_flag", trap, 1);
      chk("trap_hold_cause", trap_cause, 3);
      $display("trap held for 20 cycles");

      do_reset();
      run_instr(7'b0010011, 99, 0, mk(1, 4, 0, 0, 0, 0, 0, 0, 0, 1));  // fetch timeout

      do_reset();
      repeat (3) @(posedge clock);
      #1;
      chk("scoreboard_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Control sequencer for the multicycle successor of the single-cycle RV32I core.
- Steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK and gates the datapath write enables per phase.
- Handles variable-latency instruction and data buses through valid/ready handshakes with parametrised timeouts, and provides a sticky trap plus a retired-instruction counter.
- Sits beside the existing combinational ctlpath, which still supplies ALU/mux selects; this block supplies only timing and enables.

Parameters:
FETCH_TIMEOUT, 16, max FETCH wait cycles before trap; 0 = wait forever
MEM_TIMEOUT, 16, max MEMORY wait cycles before trap; 0 = wait forever
INSTRET_WIDTH, 32, width of retired-instruction counter

Ports:
clock  in  1  core clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 = in reset
inst_opcode  in  7  opcode field of instruction register
inst_valid  in  1  instruction bus returns data this cycle
bus_ready  in  1  data bus completes access this cycle
inst_read_enable  out  1  request instruction at pc
ir_write_enable  out  1  capture instruction into IR
data_mem_read_enable  out  1  load request
data_mem_write_enable  out  1  store request
mdr_write_enable  out  1  capture load data
regfile_write_enable  out  1  write rd
pc_write_enable  out  1  update pc with next_pc
retire  out  1  one-cycle pulse per completed instruction
instret  out  INSTRET_WIDTH  retired-instruction count
state  out  3  FETCH=0 DECODE=1 EXECUTE=2 MEMORY=3 WRITEBACK=4 TRAP=5
trap  out  1  sticky error flag
trap_cause  out  2  0 none, 1 fetch timeout, 2 memory timeout, 3 illegal opcode

Behaviour:
- Reset asserted (reset=0):
  - state=FETCH, wait counter=0, instret=0, trap=0, trap_cause=0.
  - All enable outputs and retire forced 0 while reset is low, regardless of other inputs.
- Enables and retire are combinational from state, inputs and the latched opcode class. state, instret, trap and trap_cause are registered.
- Wait counter:
  - Clears on every state change.
  - Increments each cycle spent in FETCH or MEMORY without handshake.
  - Width is clog2(max(FETCH_TIMEOUT, MEM_TIMEOUT)+1).
- FETCH: inst_read_enable=1.
  - inst_valid=1: ir_write_enable=1 in the same cycle, next state DECODE.
  - Otherwise, if FETCH_TIMEOUT!=0 and counter==FETCH_TIMEOUT-1: next TRAP, trap_cause=1.
  - inst_valid wins over timeout in the same cycle.
- DECODE:
  - Legal opcodes: LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, MISC_MEM 0001111.
  - Legal: next EXECUTE. Any other opcode (including SYSTEM): next TRAP, trap_cause=3.
- EXECUTE:
  - LOAD/STORE: next MEMORY.
  - BRANCH/MISC_MEM: pc_write_enable=1, retire=1, next FETCH.
  - All others: next WRITEBACK.
- MEMORY: data_mem_read_enable (LOAD) or data_mem_write_enable (STORE) held 1 until handshake.
  - bus_ready=1 on LOAD: mdr_write_enable=1, next WRITEBACK.
  - bus_ready=1 on STORE: pc_write_enable=1, retire=1, next FETCH.
  - Timeout (MEM_TIMEOUT!=0, counter==MEM_TIMEOUT-1, no ready): next TRAP, trap_cause=2. Ready wins over timeout.
- WRITEBACK: regfile_write_enable=1, pc_write_enable=1, retire=1, next FETCH.
- TRAP:
  - All enables 0, trap=1, state held until reset.
  - trap_cause latched on entry and never overwritten.
- instret increments by 1 on every retire cycle and wraps modulo 2^INSTRET_WIDTH.
- Zero-wait latencies (first FETCH cycle to retire cycle, inclusive):
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - BRANCH/FENCE: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each bus wait cycle adds 1.
- Reset mid-instruction: abandon the instruction, no partial enable; restart in FETCH on the first edge after reset=1.
- inst_valid outside FETCH and bus_ready outside MEMORY are ignored.
- inst_opcode is sampled in DECODE and held by the IR; later changes do not alter the path.

Test Plan:
- ADDI 0x00500093, inst_valid immediate -> states 0,1,2,4; regfile_write_enable and pc_write_enable high in cycle 4 only; instret 0->1.
- LW with bus_ready after 3 wait cycles -> MEMORY lasts 4 cycles; mdr_write_enable pulses once; retire in cycle 8; instret=1.
- BEQ then SW back-to-back -> retire at cycle 3 and cycle 7; regfile_write_enable never high; instret=2.
- Opcode 1110011 (ECALL) -> TRAP after DECODE, trap=1, trap_cause=3; all enables stay 0 for 20 further cycles.
- FETCH_TIMEOUT=4 with inst_valid low -> TRAP entered after 4 FETCH cycles, trap_cause=1.
- Same setup with inst_valid on the 4th cycle -> DECODE, no trap.
- Reset pulse (low) during MEMORY of a store -> data_mem_write_enable drops immediately; instret=0; FETCH on release; preload instret=2^32-1 (INSTRET_WIDTH=32) and retire -> wraps to 0.
